// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment pattern table and display codes for the encoder and reader sides.
package seg_pkg;
   localparam logic [4:0] CODE_BLANK   = 5'h10;
   localparam logic [4:0] CODE_DASH    = 5'h11;
   localparam logic [4:0] CODE_INVALID = 5'h1F;
   localparam logic [6:0] PAT_0 = 7'h40;
   localparam logic [6:0] PAT_1 = 7'h79;
   localparam logic [6:0] PAT_2 = 7'h24;
   localparam logic [6:0] PAT_3 = 7'h30;
   localparam logic [6:0] PAT_4 = 7'h19;
   localparam logic [6:0] PAT_5 = 7'h12;
   localparam logic [6:0] PAT_6 = 7'h02;
   localparam logic [6:0] PAT_7 = 7'h78;
   localparam logic [6:0] PAT_8 = 7'h00;
   localparam logic [6:0] PAT_9 = 7'h10;
   localparam logic [6:0] PAT_A = 7'h08;
   localparam logic [6:0] PAT_B = 7'h03;
   localparam logic [6:0] PAT_C = 7'h46;
   localparam logic [6:0] PAT_D = 7'h21;
   localparam logic [6:0] PAT_E = 7'h06;
   localparam logic [6:0] PAT_F = 7'h0E;
   localparam logic [6:0] PAT_BLANK = 7'h7F;
   localparam logic [6:0] PAT_DASH  = 7'h3F;
   // Hex digit i occupies bits [7i+6:7i].
   localparam logic [111:0] HEX_PATS = {PAT_F, PAT_E, PAT_D, PAT_C, PAT_B, PAT_A, PAT_9, PAT_8,
                                        PAT_7, PAT_6, PAT_5, PAT_4, PAT_3, PAT_2, PAT_1, PAT_0};
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps an active-low gfedcba pattern to its display code, flagging unknown patterns.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pat,
   output logic [4:0] code,
   output logic       invalid
);
   always_comb begin
      code = CODE_INVALID;
      invalid = 1'b1;
      for (int i = 0; i < 16; i++)
         if (pat == HEX_PATS[7*i +: 7]) begin
            code = 5'(i);
            invalid = 1'b0;
         end
      if (pat == PAT_BLANK) begin
         code = CODE_BLANK;
         invalid = 1'b0;
      end
      if (pat == PAT_DASH) begin
         code = CODE_DASH;
         invalid = 1'b0;
      end
   end
endmodule

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: samples a multiplexed seven-segment bus and recovers per-digit codes and full frames.
module seg_scan_reader
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   input  logic                    err_clr,
   output logic                    code_valid,
   output logic [4:0]              code_out,
   output logic [2:0]              digit_idx,
   output logic                    frame_done,
   output logic [5*NUM_DIGITS-1:0] digits_out,
   output logic                    err_invalid
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int FW = 5 * NUM_DIGITS;
   logic [6:0] seg_m_q, seg_m_d, seg_s_q, seg_s_d;
   logic [NUM_DIGITS-1:0] dig_m_q, dig_m_d, dig_s_q, dig_s_d, seen_q, seen_d;
   logic [NUM_DIGITS+6:0] prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic code_valid_q, code_valid_d, frame_done_q, frame_done_d, err_q, err_d;
   logic [4:0] code_out_q, code_out_d, pat_code;
   logic [2:0] digit_idx_q, digit_idx_d, idx;
   logic [FW-1:0] frame_q, frame_d, digits_out_q, digits_out_d;
   logic pat_inv, same, onehot, cap;
   seg_pattern_decode u_dec (.pat(seg_s_q), .code(pat_code), .invalid(pat_inv));
   always_comb begin
      seg_m_d = seg_in;
      seg_s_d = seg_m_q;
      dig_m_d = dig_sel;
      dig_s_d = dig_m_q;
      prev_d = {dig_s_q, seg_s_q};
      same = prev_d == prev_q;
      cnt_d = !same ? '0 : (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + CW'(1);
      onehot = (dig_s_q != '0) && ((dig_s_q & (dig_s_q - 1'b1)) == '0);
      // Only the single edge where the count reaches saturation captures, so a held value fires once.
      cap = same && (cnt_q == CW'(STABLE_CYCLES - 1)) && onehot;
      idx = '0;
      frame_d = frame_q;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (dig_s_q[i]) begin
            idx = 3'(i);
            if (cap) frame_d[5*i +: 5] = pat_code;
         end
      seen_d = cap ? (seen_q | dig_s_q) : seen_q;
      frame_done_d = cap && (&seen_d);
      digits_out_d = frame_done_d ? frame_d : digits_out_q;
      seen_d = frame_done_d ? '0 : seen_d;
      code_valid_d = cap;
      code_out_d = cap ? pat_code : code_out_q;
      digit_idx_d = cap ? idx : digit_idx_q;
      err_d = (cap && pat_inv) ? 1'b1 : err_clr ? 1'b0 : err_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         seg_m_q <= '0;
         seg_s_q <= '0;
         dig_m_q <= '0;
         dig_s_q <= '0;
         prev_q <= '0;
         cnt_q <= '0;
         seen_q <= '0;
         code_valid_q <= 1'b0;
         code_out_q <= '0;
         digit_idx_q <= '0;
         frame_done_q <= 1'b0;
         frame_q <= {NUM_DIGITS{CODE_BLANK}};
         digits_out_q <= {NUM_DIGITS{CODE_BLANK}};
         err_q <= 1'b0;
      end else begin
         seg_m_q <= seg_m_d;
         seg_s_q <= seg_s_d;
         dig_m_q <= dig_m_d;
         dig_s_q <= dig_s_d;
         prev_q <= prev_d;
         cnt_q <= cnt_d;
         seen_q <= seen_d;
         code_valid_q <= code_valid_d;
         code_out_q <= code_out_d;
         digit_idx_q <= digit_idx_d;
         frame_done_q <= frame_done_d;
         frame_q <= frame_d;
         digits_out_q <= digits_out_d;
         err_q <= err_d;
      end
   assign code_valid = code_valid_q;
   assign code_out = code_out_q;
   assign digit_idx = digit_idx_q;
   assign frame_done = frame_done_q;
   assign digits_out = digits_out_q;
   assign err_invalid = err_q;
endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: directed vectors with hand-computed expectations for seg_scan_reader.
module tb_seg_scan_reader;
   logic clk = 1'b0, rst = 1'b1, err_clr = 1'b0;
   logic [6:0] seg_in = 7'h7F;
   logic [3:0] dig_sel = 4'b0000;
   logic code_valid, frame_done, err_invalid;
   logic [4:0] code_out;
   logic [2:0] digit_idx;
   logic [19:0] digits_out;
   int n_cmp = 0, n_bad = 0;
   int nv, nfd, fe, tot_v;
   logic [4:0] lc;
   logic [2:0] li;
   seg_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel), .err_clr(err_clr),
      .code_valid(code_valid), .code_out(code_out), .digit_idx(digit_idx),
      .frame_done(frame_done), .digits_out(digits_out), .err_invalid(err_invalid)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Drives one bus value for n edges; err_clr is high for the edge numbered clr_e.
   task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n, input int clr_e);
      dig_sel = d;
      seg_in = s;
      nv = 0;
      nfd = 0;
      fe = -1;
      for (int e = 0; e < n; e++) begin
         err_clr = (e == clr_e);
         @(posedge clk);
         #1;
         if (code_valid) begin
            nv++;
            tot_v++;
            if (fe < 0) fe = e;
            lc = code_out;
            li = digit_idx;
         end
         if (frame_done) nfd++;
      end
      err_clr = 1'b0;
   endtask
   initial begin
      tot_v = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", code_valid, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_err", err_invalid, 0);
      chk("rst_code", code_out, 0);
      chk("rst_idx", digit_idx, 0);
      chk("rst_digits", digits_out, 20'h84210);
      rst = 1'b0;
      hold(4'b0010, 7'h24, 10, -1);
      chk("single_n", nv, 1);
      chk("single_lat", fe, 6);
      chk("single_code", lc, 5'h02);
      chk("single_idx", li, 1);
      chk("single_fd", nfd, 0);
      chk("single_digits", digits_out, 20'h84210);
      hold(4'b0001, 7'h40, 3, -1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_valid", code_valid, 0);
      chk("mid_fd", frame_done, 0);
      chk("mid_err", err_invalid, 0);
      chk("mid_digits", digits_out, 20'h84210);
      rst = 1'b0;
      hold(4'b0001, 7'h30, 8, -1);
      chk("post_first", fe, 6);
      chk("post_d0_fd", nfd, 0);
      hold(4'b0100, 7'h19, 8, -1);
      hold(4'b1000, 7'h12, 8, -1);
      chk("seen_cleared", nfd, 0);
      hold(4'b0010, 7'h02, 8, -1);
      chk("post_fd", nfd, 1);
      chk("post_digits", digits_out, 20'h290C3);
      hold(4'b0001, 7'h40, 8, -1);
      chk("f0_code", lc, 5'h00);
      hold(4'b0010, 7'h79, 8, -1);
      chk("f1_code", lc, 5'h01);
      hold(4'b0100, 7'h3F, 8, -1);
      chk("f2_code", lc, 5'h11);
      chk("f2_fd", nfd, 0);
      hold(4'b1000, 7'h7F, 8, -1);
      chk("f3_n", nv, 1);
      chk("f3_code", lc, 5'h10);
      chk("f3_idx", li, 3);
      chk("f3_fd", nfd, 1);
      chk("frame_digits", digits_out, 20'h84420);
      tot_v = 0;
      for (int i = 0; i < 8; i++) hold(4'b0001, (i % 2 == 0) ? 7'h10 : 7'h00, 2, -1);
      chk("glitch_n", tot_v, 0);
      hold(4'b0001, 7'h10, 10, -1);
      chk("glitch_hold_n", nv, 1);
      chk("glitch_code", lc, 5'h09);
      hold(4'b0100, 7'h55, 8, -1);
      chk("inv_code", lc, 5'h1F);
      chk("inv_idx", li, 2);
      chk("inv_err", err_invalid, 1);
      hold(4'b0100, 7'h01, 8, 6);
      chk("inv2_n", nv, 1);
      chk("setwins_err", err_invalid, 1);
      hold(4'b0110, 7'h40, 10, 0);
      chk("multi_n", nv, 0);
      chk("clr_err", err_invalid, 0);
      hold(4'b0000, 7'h40, 4, -1);
      hold(4'b0001, 7'h40, 8, -1);
      hold(4'b0001, 7'h12, 8, -1);
      chk("ow_code", lc, 5'h05);
      chk("ow_fd", nfd, 0);
      hold(4'b0010, 7'h79, 8, -1);
      hold(4'b0100, 7'h24, 8, -1);
      hold(4'b1000, 7'h30, 8, -1);
      chk("wrap_fd", nfd, 1);
      chk("wrap_digits", digits_out, 20'h18825);
      hold(4'b0001, 7'h7F, 8, -1);
      chk("next_n", nv, 1);
      chk("next_fd", nfd, 0);
      chk("next_digits", digits_out, 20'h18825);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Receive-side counterpart of the hex-to-segment decoder.
- Samples a multiplexed seven-segment bus (active-low segments plus one-hot digit select) and recovers the 5-bit display code shown on each digit.
- Used as an on-chip display monitor and self-check, and as the capture path for externally driven segment displays.
- Sequential elements: input synchronizers, stability filter, per-digit code registers, frame assembly.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before a capture; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines, active-low; bit6=g ... bit0=a.
- dig_sel  input  NUM_DIGITS  digit enables, active-high, one-hot when valid.
- err_clr  input  1  clears err_invalid.
- code_valid  output  1  one-cycle pulse per capture.
- code_out  output  5  captured code; valid with code_valid.
- digit_idx  output  3  index of the captured digit; valid with code_valid.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last frame.
- digits_out  output  5*NUM_DIGITS  packed frame, digit i at [5i+4:5i]; updates only on frame_done.
- err_invalid  output  1  sticky flag for an unknown segment pattern.

Behaviour:
- Reset (async, rst=1): code_valid=0, code_out=0, digit_idx=0, frame_done=0, err_invalid=0.
- Reset also sets every digits_out field to 5'h10, clears the synchronizers, stability counter and seen mask.
- Reset mid-operation discards any partial frame and suppresses pulses on the cycle reset deasserts.
- Input synchronization: seg_in and dig_sel pass through two flops each. All logic below operates on the synchronized values {dig_s, seg_s}.
- Stability filter:
  - prev register holds the last {dig_s, seg_s}.
  - If equal to current, stable_cnt increments, saturating at STABLE_CYCLES; otherwise stable_cnt clears to 0.
  - Counter width is clog2(STABLE_CYCLES+1).
- Capture event: fires on the cycle stable_cnt transitions from STABLE_CYCLES-1 to STABLE_CYCLES.
  - Exactly one capture per stable interval; a held value never re-fires.
- Capture qualification:
  - dig_s must be one-hot; zero or multi-hot selects produce no capture and no error.
  - digit_idx = position of the set bit.
- Latency: an input held constant from edge 0 produces code_valid registered at edge STABLE_CYCLES+2. This is exact and the bench checks it.
- Pattern decode (active-low gfedcba -> code):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10
  - A:08 b:03 C:46 d:21 E:06 F:0E
  - blank 7F -> 5'h10; dash 3F -> 5'h11.
  - Any other pattern -> code 5'h1F and err_invalid set.
- On capture:
  - code_out, digit_idx registered and code_valid=1 for one cycle.
  - Internal frame register field [digit_idx] <= code; seen[digit_idx] <= 1.
  - Invalid captures still count as seen.
- Frame completion:
  - When seen (including the current capture) is all ones, frame_done pulses on the same cycle as that capture's code_valid.
  - On that cycle digits_out loads the completed frame and seen clears to 0.
  - A repeated capture of an already-seen digit overwrites its field before completion.
- err_clr: clears err_invalid on the next edge. If err_clr and a new invalid capture occur in the same cycle, set wins (err_invalid=1).
- The block generates no backpressure; downstream must accept every code_valid pulse.

Decomposition:
- Shared package seg_pkg holds:
  - code constants CODE_BLANK=5'h10, CODE_DASH=5'h11, CODE_INVALID=5'h1F;
  - the 16 hex segment-pattern localparams, PAT_BLANK=7'h7F, PAT_DASH=7'h3F.
- The encoder side reuses the same package so both directions share one table.
- One combinational sub-module, seg_pattern_decode: 7-bit pattern in, 5-bit code plus invalid flag out. It is instantiated once in the capture path.

Test Plan:
- Reset: assert rst mid-stream -> all pulses 0, err_invalid=0, digits_out=20'h84210 (all 5'h10), seen cleared.
- Single capture: dig_sel=4'b0010, seg_in=7'h24 held 10 cycles -> exactly one code_valid at edge 6, code_out=5'h02, digit_idx=1, frame_done=0.
- Full frame: digits 0..3 show 7'h40, 7'h79, 7'h3F, 7'h7F, each held 8 cycles -> four code_valid pulses; frame_done with the fourth; digits_out = {5'h10, 5'h11, 5'h01, 5'h00}.
- Glitch rejection: seg_in toggles between 7'h00 and 7'h10 every 2 cycles (STABLE_CYCLES=4) -> no code_valid. Then hold 7'h10 -> one capture, code 5'h09.
- Invalid and illegal select:
  - seg_in=7'h55 stable on digit 2 -> code_out=5'h1F, err_invalid=1.
  - err_clr pulsed together with a second invalid capture -> err_invalid stays 1.
  - dig_sel=4'b0110 held -> no capture.
- Wrap and overwrite: digit 0 captured twice (7'h40 then 7'h12) before digits 1..3 -> frame_done once, field 0 = 5'h05; the next frame starts with seen cleared.
